sopc_intc: RTL and testbench
============================

SOPC_INTC -- requirements
Module: sopc_intc

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, port names clk and rst.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  asynchronous reset, active low (0 = reset).
REQ-004 ce_i  input  1  register-bus access strobe.
REQ-005 we_i  input  1  1 = write, 0 = read, qualified by ce_i.
REQ-006 addr_i  input  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
REQ-007 data_i  input  32  write data.
REQ-008 data_o  output  32  registered read data.
REQ-009 irq_i  input  5  asynchronous external interrupt sources.
REQ-010 int_o  output  6  registered interrupt lines to the CPU int_i; bit 5 is the timer.

Function
REQ-011 Register map SHALL be: 0x00 PEND (R, W1C), 0x04 MASK (RW), 0x08 MODE (RW, 1 = edge, 0 = level), 0x0C TCMP (RW, 32b), 0x10 TCNT (RW, 32b), 0x14 TCTRL (bit0 EN, bit1 AUTO).
REQ-012 Only bits [5:0] of PEND, MASK and MODE and bits [1:0] of TCTRL SHALL be implemented; unimplemented bits read 0.
REQ-013 Each irq_i bit SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; edge = s2 & ~s3.
REQ-014 Edge-mode bit: edge SHALL set PEND; a W1C write clears it; a simultaneous set and clear SHALL leave the bit set.
REQ-015 Level-mode bit: PEND SHALL track s2 each cycle; W1C writes have no effect.
REQ-016 irq_i high sampled at edge k SHALL set PEND after edge k+2 and assert int_o after edge k+3.
REQ-017 int_o SHALL be registered: int_o <= PEND & MASK[5:0].
REQ-018 MODE[5] SHALL be ignored; PEND[5] is always edge-type, set by a timer match.
REQ-019 With EN=1, TCNT SHALL increment by 1 per clk and wrap 0xFFFFFFFF -> 0.
REQ-020 On a match (TCNT == TCMP with EN=1), PEND[5] SHALL be set at the next edge, and:
  - AUTO=1: TCNT loads 0.
  - AUTO=0: TCNT holds and EN clears.
REQ-021 A bus write to TCNT SHALL take priority over increment and reload in the same cycle.
REQ-022 A bus write to TCTRL in a match cycle SHALL take priority over the EN auto-clear.
REQ-023 A read (ce_i=1, we_i=0) SHALL present data on data_o after the next edge; data_o holds its value when there is no read.
REQ-024 Reads of unmapped addresses (0x18-0x1C) SHALL return 0; writes to them are ignored.
REQ-025 Writes SHALL take effect at the edge on which ce_i & we_i is sampled.

Reset
REQ-026 On rst=0 the following SHALL clear asynchronously: PEND, MASK, MODE, TCNT, TCTRL, data_o, int_o and all synchronizer flops; TCMP resets to 0xFFFFFFFF.
REQ-027 Reset asserted mid-count or with pending interrupts SHALL discard all state; after release int_o stays 0 until a new event occurs and is unmasked.

Structure
REQ-028 Register offsets, field bit positions and the TCMP reset value SHALL live in the shared defines package as constants.
REQ-029 The per-bit synchronizer/edge detector SHALL be one sub-module, intc_sync_edge, instantiated 5 times.

Verification
REQ-030 Reset check: after rst release, read all registers -> PEND=0, MASK=0, MODE=0, TCMP=0xFFFFFFFF, TCNT=0, TCTRL=0; int_o=0.
REQ-031 Edge latency: MODE=0x01, MASK=0x01, pulse irq_i[0] high at edge k -> int_o[0]=1 after edge k+3; write PEND=0x01 -> int_o[0]=0 two edges later.
REQ-032 Level mode: MODE=0, MASK=0x04, hold irq_i[2] high 10 cycles then low -> int_o[2] follows with a 3-edge lag; a W1C write to PEND while high has no effect.
REQ-033 Timer one-shot: TCMP=5, TCTRL=0x1 -> PEND[5]=1, TCNT holds at 5, TCTRL reads 0.
REQ-034 Timer auto-reload: TCMP=3, TCTRL=0x3, MASK=0x20, W1C PEND[5] on each event -> int_o[5] fires every 4 cycles.
REQ-035 Collisions:
  - Set/clear: irq_i[1] edge coincident with a W1C of bit 1 -> PEND[1] stays 1.
  - Mid-operation reset: rst pulled low while TCNT=100 -> TCNT reads 0 after release.

Source files
------------

// File: rtl/sopc_intc_pkg.sv
// rtl/sopc_intc_pkg.sv - shared constants and types for the interrupt controller
package sopc_intc_pkg;

  // Source counts: five external lines plus the timer on the top bit
  localparam int NUM_EXT_IRQ = 5;
  localparam int NUM_INT     = 6;
  localparam int TIMER_BIT   = 5;

  // Byte offsets of the register map
  localparam logic [4:0] OFF_PEND  = 5'h00;
  localparam logic [4:0] OFF_MASK  = 5'h04;
  localparam logic [4:0] OFF_MODE  = 5'h08;
  localparam logic [4:0] OFF_TCMP  = 5'h0C;
  localparam logic [4:0] OFF_TCNT  = 5'h10;
  localparam logic [4:0] OFF_TCTRL = 5'h14;

  // Word selects as seen on addr[4:2]
  localparam logic [2:0] SEL_PEND  = OFF_PEND[4:2];
  localparam logic [2:0] SEL_MASK  = OFF_MASK[4:2];
  localparam logic [2:0] SEL_MODE  = OFF_MODE[4:2];
  localparam logic [2:0] SEL_TCMP  = OFF_TCMP[4:2];
  localparam logic [2:0] SEL_TCNT  = OFF_TCNT[4:2];
  localparam logic [2:0] SEL_TCTRL = OFF_TCTRL[4:2];

  // TCTRL field positions
  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_AUTO_BIT = 1;

  // Compare register comes out of reset at all-ones so an enabled timer runs the full range
  localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

  typedef struct packed {
    logic auto_rl;
    logic en;
  } tctrl_t;

endpackage

// File: rtl/intc_sync_edge.sv
// rtl/intc_sync_edge.sv - two-flop synchronizer with rising-edge detect for one irq line
module intc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic irq_edge
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability, s3 delays s2 by one cycle for the edge compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level    = s2;
  assign irq_edge = s2 & ~s3;

endmodule

// File: rtl/sopc_intc.sv
// rtl/sopc_intc.sv - interrupt controller with pending/mask/mode registers and a compare timer
module sopc_intc
  import sopc_intc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic                   we_i,
  input  logic [4:0]             addr_i,
  input  logic [31:0]            data_i,
  output logic [31:0]            data_o,
  input  logic [NUM_EXT_IRQ-1:0] irq_i,
  output logic [NUM_INT-1:0]     int_o
);

  logic [NUM_INT-1:0]     pend, pend_next;
  logic [NUM_INT-1:0]     mask;
  logic [NUM_INT-1:0]     mode;
  logic [31:0]            tcmp;
  logic [31:0]            tcnt, tcnt_next;
  tctrl_t                 tctrl, tctrl_next;
  logic [NUM_EXT_IRQ-1:0] sync_level, sync_edge;
  logic [31:0]            rdata;
  logic [NUM_INT-1:0]     w1c;
  logic [2:0]             sel;
  logic                   wr_en, rd_en;
  logic                   wr_pend, wr_mask, wr_mode, wr_tcmp, wr_tcnt, wr_tctrl;
  logic                   match;
  logic                   addr_unused;

  for (genvar g = 0; g < NUM_EXT_IRQ; g++) begin : g_sync
    intc_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_i[g]),
      .level    (sync_level[g]),
      .irq_edge (sync_edge[g])
    );
  end

  // Register decode: byte lanes are ignored, only the word select matters
  assign sel         = addr_i[4:2];
  assign addr_unused = ^addr_i[1:0];
  assign wr_en       = ce_i & we_i;
  assign rd_en       = ce_i & ~we_i;
  assign wr_pend     = wr_en && (sel == SEL_PEND);
  assign wr_mask     = wr_en && (sel == SEL_MASK);
  assign wr_mode     = wr_en && (sel == SEL_MODE);
  assign wr_tcmp     = wr_en && (sel == SEL_TCMP);
  assign wr_tcnt     = wr_en && (sel == SEL_TCNT);
  assign wr_tctrl    = wr_en && (sel == SEL_TCTRL);
  assign w1c         = wr_pend ? data_i[NUM_INT-1:0] : '0;

  // A match only counts while the timer is running
  assign match = tctrl.en && (tcnt == tcmp);

  // Pending update: edge bits latch until cleared (set wins over clear), level bits mirror the line
  always_comb begin
    pend_next = pend;
    for (int i = 0; i < NUM_EXT_IRQ; i++) begin
      if (mode[i]) begin
        pend_next[i] = (pend[i] & ~w1c[i]) | sync_edge[i];
      end else begin
        pend_next[i] = sync_level[i];
      end
    end
    pend_next[TIMER_BIT] = (pend[TIMER_BIT] & ~w1c[TIMER_BIT]) | match;
  end

  // Timer next state: bus writes override increment, reload and the one-shot stop
  always_comb begin
    tcnt_next  = tcnt;
    tctrl_next = tctrl;
    if (wr_tcnt) begin
      tcnt_next = data_i;
    end else if (match) begin
      tcnt_next = tctrl.auto_rl ? 32'd0 : tcnt;
    end else if (tctrl.en) begin
      tcnt_next = tcnt + 32'd1;
    end
    if (wr_tctrl) begin
      tctrl_next.en      = data_i[TCTRL_EN_BIT];
      tctrl_next.auto_rl = data_i[TCTRL_AUTO_BIT];
    end else if (match && !tctrl.auto_rl) begin
      tctrl_next.en = 1'b0;
    end
  end

  // Architectural state: pending, mask, mode and timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      tcmp  <= TCMP_RESET;
      tcnt  <= '0;
      tctrl <= '0;
    end else begin
      pend  <= pend_next;
      tcnt  <= tcnt_next;
      tctrl <= tctrl_next;
      if (wr_mask) mask <= data_i[NUM_INT-1:0];
      if (wr_mode) mode <= data_i[NUM_INT-1:0];
      if (wr_tcmp) tcmp <= data_i;
    end
  end

  // Read mux; unimplemented bits and the two unmapped words return zero
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_PEND:  rdata[NUM_INT-1:0] = pend;
      SEL_MASK:  rdata[NUM_INT-1:0] = mask;
      SEL_MODE:  rdata[NUM_INT-1:0] = mode;
      SEL_TCMP:  rdata = tcmp;
      SEL_TCNT:  rdata = tcnt;
      SEL_TCTRL: begin
        rdata[TCTRL_EN_BIT]   = tctrl.en;
        rdata[TCTRL_AUTO_BIT] = tctrl.auto_rl;
      end
      default:   rdata = '0;
    endcase
  end

  // Read data is registered and held between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o <= '0;
    end else if (rd_en) begin
      data_o <= rdata;
    end
  end

  // CPU interrupt lines are registered from the masked pending bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_o <= '0;
    end else begin
      int_o <= pend & mask;
    end
  end

endmodule

// File: tb/tb_sopc_intc.sv
// tb/tb_sopc_intc.sv - randomized and directed self-checking bench for sopc_intc
module tb_sopc_intc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [4:0]  irq_i = '0;
  logic [31:0] data_o;
  logic [5:0]  int_o;

  sopc_intc dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .irq_i  (irq_i),
    .int_o  (int_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, advanced once per clock edge
  logic [5:0]  m_pend, m_mask, m_mode, m_int;
  logic [31:0] m_tcmp, m_tcnt, m_dout;
  logic        m_en, m_auto;
  logic [4:0]  hist [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0: return {26'd0, m_pend};
      1: return {26'd0, m_mask};
      2: return {26'd0, m_mode};
      3: return m_tcmp;
      4: return m_tcnt;
      5: return {30'd0, m_auto, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_int = '0;
    m_tcmp = 32'hFFFF_FFFF; m_tcnt = '0; m_dout = '0;
    m_en = 1'b0; m_auto = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock: derive the next model state from the rules, apply the edge, compare outputs
  task automatic cycle();
    int          idx;
    logic        wr, rd, match;
    logic [5:0]  w1c, np, ni;
    logic [31:0] nd, ncnt, ncmp;
    logic [5:0]  nmask, nmode;
    logic        nen, nauto;
    idx   = int'(addr_i[4:2]);
    wr    = ce_i && we_i;
    rd    = ce_i && !we_i;
    nd    = rd ? m_reg(idx) : m_dout;
    ni    = m_pend & m_mask;
    w1c   = (wr && idx == 0) ? data_i[5:0] : 6'd0;
    // hist[1] is the line value two edges back, hist[2] three edges back
    for (int i = 0; i < 5; i++) begin
      if (m_mode[i]) np[i] = (m_pend[i] && !w1c[i]) || (hist[1][i] && !hist[2][i]);
      else           np[i] = hist[1][i];
    end
    match = m_en && (m_tcnt == m_tcmp);
    np[5] = (m_pend[5] && !w1c[5]) || match;
    if (wr && idx == 4)  ncnt = data_i;
    else if (match)      ncnt = m_auto ? 32'd0 : m_tcnt;
    else if (m_en)       ncnt = m_tcnt + 32'd1;
    else                 ncnt = m_tcnt;
    nen   = m_en;
    nauto = m_auto;
    if (wr && idx == 5) begin
      nen = data_i[0];
      nauto = data_i[1];
    end else if (match && !m_auto) begin
      nen = 1'b0;
    end
    nmask = (wr && idx == 1) ? data_i[5:0] : m_mask;
    nmode = (wr && idx == 2) ? data_i[5:0] : m_mode;
    ncmp  = (wr && idx == 3) ? data_i : m_tcmp;
    @(posedge clk);
    m_pend = np; m_int = ni; m_dout = nd; m_tcnt = ncnt; m_en = nen; m_auto = nauto;
    m_mask = nmask; m_mode = nmode; m_tcmp = ncmp;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_i;
    #1;
    check("int_o", {26'd0, int_o}, {26'd0, m_int});
    check("data_o", data_o, m_dout);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr_i = a; data_i = d; ce_i = 1'b1; we_i = 1'b1;
    cycle();
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
    addr_i = a; ce_i = 1'b1; we_i = 1'b0;
    cycle();
    ce_i = 1'b0;
    v = data_o;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    ce_i = 1'b0; we_i = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    check("rst_int", {26'd0, int_o}, 32'd0);
    check("rst_dout", data_o, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int          pulses [$];
    int          sel;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset values of every register
    bus_read(5'h00, v); check("rst_pend", v, 32'd0);
    bus_read(5'h04, v); check("rst_mask", v, 32'd0);
    bus_read(5'h08, v); check("rst_mode", v, 32'd0);
    bus_read(5'h0C, v); check("rst_tcmp", v, 32'hFFFF_FFFF);
    bus_read(5'h10, v); check("rst_tcnt", v, 32'd0);
    bus_read(5'h14, v); check("rst_tctrl", v, 32'd0);
    check("rst_int_o", {26'd0, int_o}, 32'd0);

    // Edge latency: one-cycle pulse at edge k shows on int_o after edge k+3
    bus_write(5'h08, 32'h1);
    bus_write(5'h04, 32'h1);
    irq_i[0] = 1'b1;
    cycle();
    irq_i[0] = 1'b0;
    cycle(); check("edge_k1", {31'd0, int_o[0]}, 32'd0);
    cycle(); check("edge_k2", {31'd0, int_o[0]}, 32'd0);
    cycle(); check("edge_k3", {31'd0, int_o[0]}, 32'd1);
    bus_write(5'h00, 32'h1); check("w1c_e1", {31'd0, int_o[0]}, 32'd1);
    cycle();                 check("w1c_e2", {31'd0, int_o[0]}, 32'd0);

    // Level mode: int_o[2] lags the line by three edges, W1C while high does nothing
    bus_write(5'h08, 32'h0);
    bus_write(5'h04, 32'h4);
    for (int j = 0; j < 16; j++) begin
      irq_i[2] = (j < 10);
      if (j == 6) begin
        ce_i = 1'b1; we_i = 1'b1; addr_i = 5'h00; data_i = 32'h4;
      end
      cycle();
      ce_i = 1'b0; we_i = 1'b0;
      check("lvl_lag", {31'd0, int_o[2]}, (j >= 3 && j <= 12) ? 32'd1 : 32'd0);
    end

    // Timer one-shot
    bus_write(5'h04, 32'h0);
    bus_write(5'h0C, 32'd5);
    bus_write(5'h14, 32'h1);
    idle(10);
    bus_read(5'h00, v); check("os_pend", v, 32'h20);
    bus_read(5'h10, v); check("os_tcnt", v, 32'd5);
    bus_read(5'h14, v); check("os_tctrl", v, 32'd0);
    bus_write(5'h00, 32'h20);

    // Timer auto-reload with a W1C of PEND[5] every cycle
    bus_write(5'h10, 32'd0);
    bus_write(5'h0C, 32'd3);
    bus_write(5'h04, 32'h20);
    bus_write(5'h14, 32'h3);
    for (int j = 0; j < 24; j++) begin
      ce_i = 1'b1; we_i = 1'b1; addr_i = 5'h00; data_i = 32'h20;
      cycle();
      if (int_o[5]) pulses.push_back(j);
    end
    ce_i = 1'b0; we_i = 1'b0;
    check("ar_count", {31'd0, pulses.size() >= 4}, 32'd1);
    for (int i = 1; i < pulses.size(); i++)
      check("ar_period", pulses[i] - pulses[i-1], 32'd4);
    bus_write(5'h14, 32'h0);
    bus_write(5'h00, 32'h3F);

    // Set/clear collision: edge sets PEND[1] on the same edge as its W1C
    bus_write(5'h08, 32'h2);
    bus_write(5'h04, 32'h2);
    irq_i[1] = 1'b1;
    cycle();
    cycle();
    bus_write(5'h00, 32'h2);
    bus_read(5'h00, v); check("setclr", v & 32'h2, 32'h2);
    irq_i[1] = 1'b0;
    bus_write(5'h00, 32'h2);
    idle(3);

    // Counter wrap and unmapped words
    bus_write(5'h04, 32'h0);
    bus_write(5'h0C, 32'd1);
    bus_write(5'h10, 32'hFFFF_FFFE);
    bus_write(5'h14, 32'h1);
    idle(5);
    bus_read(5'h10, v); check("wrap_tcnt", v, 32'd1);
    bus_write(5'h18, 32'hDEAD_BEEF);
    bus_read(5'h18, v); check("unmap18", v, 32'd0);
    bus_read(5'h1F, v); check("unmap1c", v, 32'd0);
    bus_read(5'h07, v); check("lane_mask", v, 32'd0);

    // Reset in the middle of counting
    bus_write(5'h0C, 32'd1000);
    bus_write(5'h10, 32'd90);
    bus_write(5'h14, 32'h1);
    idle(10);
    bus_read(5'h10, v); check("mid_tcnt", v, 32'd100);
    do_reset();
    bus_read(5'h10, v); check("post_tcnt", v, 32'd0);
    bus_read(5'h0C, v); check("post_tcmp", v, 32'hFFFF_FFFF);
    check("post_int", {26'd0, int_o}, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) irq_i[b] = ~irq_i[b];
      ce_i = 1'b0; we_i = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          ce_i = 1'b1; we_i = 1'b0;
          addr_i = 5'($urandom_range(0, 31));
        end
        3, 4: begin
          sel = $urandom_range(0, 7);
          ce_i = 1'b1; we_i = 1'b1;
          addr_i = {3'(sel), 2'($urandom_range(0, 3))};
          data_i = (sel == 3 || sel == 4) ? 32'($urandom_range(0, 24)) : $urandom;
        end
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    ce_i = 1'b0; we_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
